// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared encodings for the traffic light sequencer
package tlc_pkg;

    // Traffic mode as delivered by the mode-selection stage
    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    // Lamp patterns, bit order {R,Y,G}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Intersection phases; the encoding is exported on the phase debug port
    typedef enum logic [3:0] {
        ST_ALL_RED_1  = 4'd0,
        ST_NS_GREEN   = 4'd1,
        ST_NS_YELLOW  = 4'd2,
        ST_ALL_RED_2  = 4'd3,
        ST_EW_GREEN   = 4'd4,
        ST_EW_YELLOW  = 4'd5,
        ST_PED_WALK   = 4'd6,
        ST_EMG_HOLD   = 4'd7,
        ST_FLASH      = 4'd8
    } state_t;

    // Clearance phase a pedestrian walk hands back to (0 -> ALL_RED_1, 1 -> ALL_RED_2)
    function automatic state_t ret_clearance(input logic ret_dir);
        return ret_dir ? ST_ALL_RED_2 : ST_ALL_RED_1;
    endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// rtl/traffic_light_sequencer_if.sv - mode in / lamps out bundle; TLC_WALK_COUNTDOWN_EN adds walk_remaining
interface traffic_light_sequencer_if
`ifdef TLC_WALK_COUNTDOWN_EN
    #(parameter int CNT_W = 8)
`endif
    ;

    logic [1:0] mode;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_served;
    logic [3:0] phase;
`ifdef TLC_WALK_COUNTDOWN_EN
    logic [CNT_W-1:0] walk_remaining;

    // Sequencer side: consumes mode, drives lamps
    modport master (
        input  mode,
        output ns_light, ew_light, walk, ped_served, phase, walk_remaining
    );

    // Lamp-driver / mode-stage side
    modport slave (
        output mode,
        input  ns_light, ew_light, walk, ped_served, phase, walk_remaining
    );
`else
    // Sequencer side: consumes mode, drives lamps
    modport master (
        input  mode,
        output ns_light, ew_light, walk, ped_served, phase
    );

    // Lamp-driver / mode-stage side
    modport slave (
        output mode,
        input  ns_light, ew_light, walk, ped_served, phase
    );
`endif

endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that times each intersection phase
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign done  = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - intersection phase FSM and lamp drive; TLC_WALK_COUNTDOWN_EN adds walk_remaining
module traffic_light_sequencer
    import tlc_pkg::*;
#(
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10,
    parameter int FLASH_HALF   = 5,
    parameter int CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    traffic_light_sequencer_if.master bus
);

    // Timer reload values: a phase of N ticks counts N-1 down to 0
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);

    state_t state_q;
    state_t state_d;
    logic   ped_pending_q;
    logic   ped_pending_d;
    logic   ret_dir_q;
    logic   ret_dir_d;
    logic   flash_phase_q;
    logic   flash_phase_d;
    logic   ped_served_q;
    logic   ped_served_d;

    logic             entering;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_done;

    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;

    // Shared phase timer; also paces the night flashing half-periods
    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LD)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ALL_RED_1;
            ped_pending_q <= 1'b0;
            ret_dir_q     <= 1'b0;
            flash_phase_q <= 1'b1;
            ped_served_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            ret_dir_q     <= ret_dir_d;
            flash_phase_q <= flash_phase_d;
            ped_served_q  <= ped_served_d;
        end
    end

    // Next-state decision; emergency truncates greens and walks but never a yellow
    always_comb begin
        state_d   = state_q;
        ret_dir_d = ret_dir_q;
        case (state_q)
            ST_ALL_RED_1, ST_ALL_RED_2: begin
                if (tmr_done) begin
                    if (bus.mode == MODE_EMG) begin
                        state_d = ST_EMG_HOLD;
                    end else if (ped_pending_q) begin
                        state_d   = ST_PED_WALK;
                        ret_dir_d = (state_q == ST_ALL_RED_2);
                    end else if (bus.mode == MODE_NIGHT) begin
                        state_d = ST_FLASH;
                    end else begin
                        state_d = (state_q == ST_ALL_RED_1) ? ST_NS_GREEN : ST_EW_GREEN;
                    end
                end
            end
            ST_NS_GREEN: begin
                if (tmr_done || bus.mode == MODE_EMG) begin
                    state_d = ST_NS_YELLOW;
                end
            end
            ST_NS_YELLOW: begin
                if (tmr_done) begin
                    state_d = ST_ALL_RED_2;
                end
            end
            ST_EW_GREEN: begin
                if (tmr_done || bus.mode == MODE_EMG) begin
                    state_d = ST_EW_YELLOW;
                end
            end
            ST_EW_YELLOW: begin
                if (tmr_done) begin
                    state_d = ST_ALL_RED_1;
                end
            end
            ST_PED_WALK: begin
                if (tmr_done || bus.mode == MODE_EMG) begin
                    state_d = ret_clearance(ret_dir_q);
                end
            end
            ST_EMG_HOLD: begin
                if (bus.mode != MODE_EMG) begin
                    state_d = ST_ALL_RED_1;
                end
            end
            ST_FLASH: begin
                if (bus.mode != MODE_NIGHT) begin
                    state_d = ST_ALL_RED_1;
                end
            end
            default: begin
                state_d = ST_ALL_RED_1;
            end
        endcase
    end

    // Timer reloads on every phase entry and every flash half-period; pedestrian latch and flash toggle
    always_comb begin
        entering     = (state_d != state_q);
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (entering) begin
            tmr_load = 1'b1;
            case (state_d)
                ST_NS_GREEN, ST_EW_GREEN:   tmr_load_val = GREEN_LD;
                ST_NS_YELLOW, ST_EW_YELLOW: tmr_load_val = YELLOW_LD;
                ST_ALL_RED_1, ST_ALL_RED_2: tmr_load_val = ALLRED_LD;
                ST_PED_WALK:                tmr_load_val = WALK_LD;
                ST_FLASH:                   tmr_load_val = FLASH_LD;
                default:                    tmr_load_val = '0;
            endcase
        end else if (state_q == ST_FLASH && tmr_done) begin
            tmr_load     = 1'b1;
            tmr_load_val = FLASH_LD;
        end

        flash_phase_d = flash_phase_q;
        if (entering && state_d == ST_FLASH) begin
            flash_phase_d = 1'b1;
        end else if (state_q == ST_FLASH && tmr_done) begin
            flash_phase_d = ~flash_phase_q;
        end

        ped_served_d  = entering && (state_d == ST_PED_WALK);
        ped_pending_d = ped_pending_q;
        if (ped_served_d) begin
            ped_pending_d = 1'b0;
        end else if (bus.mode == MODE_PED && state_q != ST_PED_WALK) begin
            ped_pending_d = 1'b1;
        end
    end

    // Moore lamp decode: red on both sides unless a direction owns the phase
    always_comb begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
        walk     = 1'b0;
        case (state_q)
            ST_NS_GREEN:  ns_light = LAMP_G;
            ST_NS_YELLOW: ns_light = LAMP_Y;
            ST_EW_GREEN:  ew_light = LAMP_G;
            ST_EW_YELLOW: ew_light = LAMP_Y;
            ST_PED_WALK:  walk     = 1'b1;
            ST_FLASH: begin
                ns_light = flash_phase_q ? LAMP_Y : LAMP_OFF;
                ew_light = flash_phase_q ? LAMP_R : LAMP_OFF;
            end
            default: begin
                ns_light = LAMP_R;
                ew_light = LAMP_R;
            end
        endcase
    end

    assign bus.ns_light   = ns_light;
    assign bus.ew_light   = ew_light;
    assign bus.walk       = walk;
    assign bus.ped_served = ped_served_q;
    assign bus.phase      = state_q;

`ifdef TLC_WALK_COUNTDOWN_EN
    assign bus.walk_remaining = (state_q == ST_PED_WALK) ? tmr_count : '0;
`else
    logic unused_tmr_count;
    assign unused_tmr_count = ^tmr_count;
`endif

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb/tb_traffic_light_sequencer.sv - directed plus randomized checks against a phase-table model
module tb_traffic_light_sequencer;
    import tlc_pkg::*;

    localparam int G  = 4;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int W  = 3;
    localparam int FH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_light_sequencer_if tif();

    traffic_light_sequencer #(
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .ALLRED_TICKS (AR),
        .WALK_TICKS   (W),
        .FLASH_HALF   (FH),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Normal day ring and the length of each of its phases
    state_t ring[6]     = '{ST_ALL_RED_1, ST_NS_GREEN, ST_NS_YELLOW, ST_ALL_RED_2, ST_EW_GREEN, ST_EW_YELLOW};
    int     ring_len[6] = '{AR, G, Y, AR, G, Y};

    state_t m_ph;
    int     m_age;
    bit     m_pend;
    bit     m_ret;
    bit     m_served;

    function automatic int ring_pos(input state_t s);
        for (int i = 0; i < 6; i++) begin
            if (ring[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ph     = ST_ALL_RED_1;
        m_age    = 0;
        m_pend   = 1'b0;
        m_ret    = 1'b0;
        m_served = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] m);
        int     k;
        bit     fin;
        state_t nx;
        k   = ring_pos(m_ph);
        nx  = m_ph;
        fin = (k >= 0) && (m_age >= ring_len[k] - 1);
        if (m_ph == ST_ALL_RED_1 || m_ph == ST_ALL_RED_2) begin
            if (fin) begin
                if (m == 2'b11) nx = ST_EMG_HOLD;
                else if (m_pend) begin
                    nx    = ST_PED_WALK;
                    m_ret = (m_ph == ST_ALL_RED_2);
                end else if (m == 2'b01) nx = ST_FLASH;
                else nx = ring[k + 1];
            end
        end else if (m_ph == ST_NS_GREEN || m_ph == ST_EW_GREEN) begin
            if (fin || m == 2'b11) nx = ring[k + 1];
        end else if (k >= 0) begin
            if (fin) nx = ring[(k + 1) % 6];
        end else if (m_ph == ST_PED_WALK) begin
            if (m_age == W - 1 || m == 2'b11) nx = m_ret ? ST_ALL_RED_2 : ST_ALL_RED_1;
        end else if (m_ph == ST_EMG_HOLD) begin
            if (m != 2'b11) nx = ST_ALL_RED_1;
        end else begin
            if (m != 2'b01) nx = ST_ALL_RED_1;
        end
        m_served = (nx == ST_PED_WALK) && (m_ph != ST_PED_WALK);
        if (m_served) m_pend = 1'b0;
        else if (m == 2'b10 && m_ph != ST_PED_WALK) m_pend = 1'b1;
        m_age = (nx == m_ph) ? m_age + 1 : 0;
        m_ph  = nx;
    endtask

    function automatic logic [2:0] exp_ns();
        case (m_ph)
            ST_NS_GREEN:  return 3'b001;
            ST_NS_YELLOW: return 3'b010;
            ST_FLASH:     return ((m_age / FH) % 2 == 0) ? 3'b010 : 3'b000;
            default:      return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew();
        case (m_ph)
            ST_EW_GREEN:  return 3'b001;
            ST_EW_YELLOW: return 3'b010;
            ST_FLASH:     return ((m_age / FH) % 2 == 0) ? 3'b100 : 3'b000;
            default:      return 3'b100;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ns_light",   8'(tif.ns_light),   8'(exp_ns()));
        chk("ew_light",   8'(tif.ew_light),   8'(exp_ew()));
        chk("walk",       8'(tif.walk),       8'(m_ph == ST_PED_WALK));
        chk("ped_served", 8'(tif.ped_served), 8'(m_served));
        chk("phase",      8'(tif.phase),      8'(m_ph));
`ifdef TLC_WALK_COUNTDOWN_EN
        chk("walk_remaining", tif.walk_remaining, (m_ph == ST_PED_WALK) ? 8'(W - 1 - m_age) : 8'd0);
`endif
    endtask

    // Called at a falling edge: drive mode, advance model on the rising edge, check on the next fall
    task automatic tick(input logic [1:0] m);
        tif.mode = m;
        @(posedge clk);
        model_step(m);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic run_until(input state_t s, input int age, input logic [1:0] m, input int budget);
        int left;
        left = budget;
        while (!(m_ph == s && m_age == age) && left > 0) begin
            tick(m);
            left--;
        end
        n_tests++;
        assert (m_ph == s && m_age == age) else begin
            n_fail++;
            $error("FAIL wait_phase cycle %0d: observed phase %0d expected %0d", cyc, m_ph, s);
        end
    endtask

    initial begin
        int          r;
        int          hold;
        logic [1:0]  rm;

        tif.mode = 2'b00;
        rst_n    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Day ring, a little over two full 14-cycle periods
        repeat (30) tick(2'b00);

        // One-cycle pedestrian request during NS green
        run_until(ST_NS_GREEN, 0, 2'b00, 40);
        tick(2'b10);
        repeat (25) tick(2'b00);

        // Emergency on the second NS green cycle, then release
        run_until(ST_NS_GREEN, 1, 2'b00, 40);
        repeat (8) tick(2'b11);
        repeat (10) tick(2'b00);

        // Night flashing and exit
        repeat (15) tick(2'b01);
        repeat (6) tick(2'b00);

        // Emergency on the first walk cycle
        run_until(ST_NS_GREEN, 0, 2'b00, 40);
        tick(2'b10);
        run_until(ST_PED_WALK, 0, 2'b00, 40);
        repeat (4) tick(2'b11);
        repeat (8) tick(2'b00);

        // Randomized mode bursts
        repeat (80) begin
            r    = $urandom_range(0, 9);
            rm   = (r < 4) ? 2'b00 : (r < 6) ? 2'b10 : (r < 8) ? 2'b01 : 2'b11;
            hold = $urandom_range(1, 12);
            repeat (hold) tick(rm);
        end
        repeat (20) tick(2'b00);

        // Asynchronous reset in the middle of EW green
        run_until(ST_EW_GREEN, 1, 2'b00, 60);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (20) tick(2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
